// File: rtl/sext_accum.sv
// Block accumulator of sign-extended 8/16-bit samples with a ready/valid result hold stage.
// Build option: define SEXT_ACCUM_SAT_EN to clamp on signed overflow instead of wrapping.
module sext_accum #(
    parameter int unsigned BLOCK_LEN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sel,
    input  logic [7:0]  in_8,
    input  logic [15:0] in_16,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_sum,
    output logic [31:0] out_sum_ext,
    output logic        ovf
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [DATA_W-1:0]   acc;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   sample_c;
    logic [DATA_W-1:0]   sum_c;
    logic [DATA_W-1:0]   acc_nxt_c;
    logic                add_ovf_c;
    logic                accept_c;
    logic                last_c;
    logic                release_c;

    // Handshake qualifiers; clear blocks acceptance in the same cycle
    assign in_ready  = (state == ACC) && !clear;
    assign accept_c  = in_valid && in_ready;
    assign last_c    = accept_c && (cnt == CNT_W'(BLOCK_LEN - 1));
    assign release_c = (state == HOLD) && out_ready;

    // Sample selection, add and overflow detection
    always_comb begin
        sample_c  = in_sel ? in_16 : {{8{in_8[7]}}, in_8};
        sum_c     = acc + sample_c;
        add_ovf_c = (acc[DATA_W-1] == sample_c[DATA_W-1]) &&
                    (sum_c[DATA_W-1] != acc[DATA_W-1]);
`ifdef SEXT_ACCUM_SAT_EN
        if (add_ovf_c) begin
            acc_nxt_c = acc[DATA_W-1] ? 16'h8000 : 16'h7FFF;
        end else begin
            acc_nxt_c = sum_c;
        end
`else
        acc_nxt_c = sum_c;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: clear overrides both handshakes
    always_comb begin
        state_nxt = state;
        case (state)
            ACC:     if (last_c)    state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = ACC;
            default: state_nxt = ACC;
        endcase
        if (clear) begin
            state_nxt = ACC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear || release_c) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (accept_c) begin
            acc <= acc_nxt_c;
            cnt <= cnt + 1'b1;
            if (add_ovf_c) begin
                ovf <= 1'b1;
            end
        end
    end

    assign out_valid   = (state == HOLD);
    assign out_sum     = acc;
    assign out_sum_ext = {{16{acc[DATA_W-1]}}, acc};

endmodule

// File: doc/sext_accum.md
SEXT_ACCUM -- requirements
Module: sext_accum

Interface
REQ-001 The block SHALL have parameter BLOCK_LEN, default 4, meaning the number of samples summed per block (legal 1..255).
REQ-002 The block SHALL have port clk, input, 1, the only clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1: one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port clear, input, 1, synchronous abort of the current block.
REQ-005 The block SHALL have port in_valid, input, 1, upstream sample valid.
REQ-006 The block SHALL have port in_ready, output, 1, block accepts a sample this cycle.
REQ-007 The block SHALL have port in_sel, input, 1: 0 = use in_8, 1 = use in_16.
REQ-008 The block SHALL have ports in_8, input, 8, and in_16, input, 16, signed two's-complement samples.
REQ-009 The block SHALL have port out_valid, output, 1, block result valid.
REQ-010 The block SHALL have port out_ready, input, 1, downstream takes result.
REQ-011 The block SHALL have ports out_sum, output, 16, signed block sum, and out_sum_ext, output, 32, out_sum sign-extended to 32 bits.
REQ-012 The block SHALL have port ovf, output, 1, signed overflow occurred in the current/held block.

Function
REQ-013 The block SHALL implement the two-state FSM ACC (collecting samples) and HOLD (result presented).
REQ-014 in_ready SHALL equal (state==ACC) and not clear; a sample is accepted iff in_valid and in_ready are both 1.
REQ-015 An accepted sample SHALL be {8{in_8[7]},in_8} when in_sel=0 and in_16 when in_sel=1, added to the 16-bit accumulator.
REQ-016 A sample counter SHALL count accepted samples; on the acceptance that brings it to BLOCK_LEN, the FSM SHALL move to HOLD on the next edge.
REQ-017 out_valid SHALL be 1 exactly while in HOLD, asserting the cycle after the last sample is accepted (latency 1).
REQ-018 out_sum, out_sum_ext and ovf SHALL stay stable throughout HOLD, regardless of input activity.
REQ-019 In HOLD with out_ready=1, the block SHALL go to ACC, with accumulator, counter and ovf cleared to 0 on that edge.
REQ-020 No sample SHALL be accepted in the HOLD cycle where the handshake completes; the next block's first sample is accepted one cycle later at the earliest.
REQ-021 Signed overflow (operand signs equal, result sign differs) SHALL set ovf, which remains set until the block ends.
REQ-022 In ACC, out_sum and out_sum_ext SHALL show the running partial sum.
REQ-023 With clear=1 in any state, the block SHALL go to ACC with accumulator, counter and ovf set to 0; clear SHALL take priority over both handshakes, and a simultaneously offered sample SHALL be dropped.
REQ-024 With BLOCK_LEN=1, every accepted sample SHALL produce a HOLD phase.

Reset
REQ-025 With rst=1 at a clock edge: state=ACC, accumulator=0, counter=0, ovf=0, out_valid=0, out_sum=0, out_sum_ext=0, in_ready=1 (after the rst is released).
REQ-026 rst SHALL override clear and all handshakes; asserting it mid-block or in HOLD SHALL discard the partial or held result.

Configuration
REQ-027 Macro SEXT_ACCUM_SAT_EN: when defined, an overflowing add SHALL clamp to 0x7FFF (positive overflow) or 0x8000 (negative overflow).
REQ-028 Without SEXT_ACCUM_SAT_EN, additions SHALL wrap modulo 2^16; ovf behaviour is identical in both builds.

Verification
REQ-029 Reset -> out_valid=0, in_ready=1, out_sum=0x0000, out_sum_ext=0x00000000, ovf=0.
REQ-030 BLOCK_LEN=4, in_sel=0, samples in_8=0x81,0x01,0xFF,0xC3, out_ready=1 -> one cycle after the 4th sample, out_valid=1, out_sum=0xFF44, out_sum_ext=0xFFFFFF44, ovf=0.
REQ-031 in_sel=1, samples in_16=0x7007,0x7007,0x0001,0x0000 -> wrap build: out_sum=0xE00F, ovf=1; SEXT_ACCUM_SAT_EN build: out_sum=0x7FFF, out_sum_ext=0x00007FFF, ovf=1.
REQ-032 Block complete, out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_sum stable; out_ready=1 -> next edge ACC, sum=0, no samples lost or double-counted.
REQ-033 clear=1 after 2 of 4 samples, with in_valid=1 the same cycle -> sample dropped, sum=0, counter=0; the next 4 samples form a full block.
REQ-034 rst=1 asserted during HOLD -> out_valid=0 next cycle, out_sum=0, ovf=0.
